busca_pc: RTL and testbench
===========================

Name: busca_pc

Overview:
- Instruction fetch / program-counter stage of the nRisk 8-bit core.
- Sits directly upstream of the instruction memory: drives the `linha` address that the memory consumes.
- Sequences fall-through, branch, call and return.
- Holds a small hardware return-address stack.
- Freezes on stall, halt or fault.

Parameters:
- ADDR_W, 8, width of the address and target buses.
- MEM_DEPTH, 16, number of instruction lines; all addresses are taken modulo MEM_DEPTH.
- RESET_VEC, 0, first address fetched after reset.
- STACK_DEPTH, 4, number of return-address stack entries.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the current address for this cycle.
- halt  in  1  halt instruction decoded; stop fetching.
- desvio  in  1  taken branch/jump this cycle.
- chamada  in  1  call: push the return address, then jump.
- retorno  in  1  return: pop the stack into the PC.
- alvo  in  ADDR_W  branch/call target address.
- linha  out  ADDR_W  address presented to instruction memory.
- valido  out  1  `linha` is a real fetch address.
- parado  out  1  block is in HALT.
- erro  out  2  fault code: 0 none, 1 stack overflow, 2 stack underflow, 3 control conflict or target out of range.
- nivel  out  log2(STACK_DEPTH)+1  current stack occupancy.

Behaviour:
- Reset:
  - State := BOOT, `linha` := RESET_VEC, `valido` := 0, `parado` := 0, `erro` := 0, `nivel` := 0.
  - Stack contents are don't-care.
  - Reset is asynchronous: it takes effect immediately and overrides everything, including mid-operation.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one clock after reset deasserts.
  - Next edge: state := RUN, `valido` := 1.
  - `linha` stays RESET_VEC, so RESET_VEC is the first valid fetch.
  - All control inputs are ignored in BOOT.
- RUN, per rising edge, in priority order:
  1. Illegal cases:
     - More than one of {desvio, chamada, retorno} asserted, or desvio/chamada with `alvo` >= MEM_DEPTH → HALT, `erro` := 3.
  2. halt → HALT, `erro` unchanged (0).
  3. stall → `linha` held, stack held. Stall also masks desvio/chamada/retorno that cycle; the decoder re-presents them.
  4. retorno:
     - `nivel` == 0 → HALT, `erro` := 2.
     - Otherwise `linha` := top entry, `nivel` decrements.
  5. chamada:
     - `nivel` == STACK_DEPTH → HALT, `erro` := 1.
     - Otherwise push (`linha`+1) mod MEM_DEPTH, `linha` := `alvo`, `nivel` increments.
  6. desvio → `linha` := `alvo`.
  7. Otherwise `linha` := (`linha`+1) mod MEM_DEPTH; wraps MEM_DEPTH-1 → 0.
- Latency: the new address is visible one clock after the control input is sampled; there is no combinational path from inputs to `linha`.
- HALT:
  - `valido` := 0, `parado` := 1.
  - `linha`, `nivel` and `erro` are frozen at their values at entry (`linha` keeps the faulting or halting address).
  - The block leaves HALT only via reset.
- `valido` is 1 only in RUN.
- `erro` is sticky until reset.
- The stack is LIFO. A push and a pop in the same cycle cannot occur; that case is caught by rule 1.

Test Plan:
- Reset release, no controls for 18 cycles → `linha` shows 0 for two cycles (BOOT then first RUN), then 1..15, 0, 1; `valido` rises after the BOOT cycle; `erro` = 0.
- Branch, then stall:
  - In RUN at `linha`=3, pulse desvio with `alvo`=9 → next `linha`=9, then 10.
  - Assert stall for 3 cycles with desvio=1, `alvo`=2 → `linha` holds for 3 cycles, branch ignored.
- Call/return:
  - At `linha`=4, chamada with `alvo`=12 → `linha`=12, `nivel`=1.
  - Two cycles later (`linha`=14), retorno → `linha`=5, `nivel`=0.
- Stack overflow:
  - Five consecutive chamada (`alvo`=1) → `nivel` reaches 4.
  - Fifth call → `parado`=1, `erro`=1, `valido`=0, `linha` frozen at 1.
- Underflow and conflict:
  - From reset, retorno → `erro`=2, `parado`=1.
  - After a new reset, desvio+chamada together → `erro`=3.
  - After a new reset, desvio with `alvo`=20 → `erro`=3.
- Halt and async reset:
  - halt at `linha`=7 → `parado`=1, `linha` stays 7 for 10 cycles despite toggling controls.
  - Assert reset between clock edges → outputs go to reset values immediately, before the next edge.

Source files
------------

// File: rtl/busca_pc.sv
// rtl/busca_pc.sv - nRisk program-counter / fetch stage with return-address stack
// Sequences fall-through, branch, call and return; freezes in HALT until reset.
module busca_pc #(
  parameter  int ADDR_W      = 8,
  parameter  int MEM_DEPTH   = 16,
  parameter  int RESET_VEC   = 0,
  parameter  int STACK_DEPTH = 4,
  localparam int NIVEL_W     = $clog2(STACK_DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               halt,
  input  logic               desvio,
  input  logic               chamada,
  input  logic               retorno,
  input  logic [ADDR_W-1:0]  alvo,
  output logic [ADDR_W-1:0]  linha,
  output logic               valido,
  output logic               parado,
  output logic [1:0]         erro,
  output logic [NIVEL_W-1:0] nivel
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0]  L_RESET = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0]  L_LAST  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]    L_DEPTH = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [NIVEL_W-1:0] L_FULL  = NIVEL_W'(STACK_DEPTH);

  localparam logic [1:0] E_OVF  = 2'd1;
  localparam logic [1:0] E_UNF  = 2'd2;
  localparam logic [1:0] E_CTRL = 2'd3;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_linha;
  logic [ADDR_W-1:0]  w_linha_nxt;
  logic [NIVEL_W-1:0] r_nivel;
  logic [NIVEL_W-1:0] w_nivel_nxt;
  logic [1:0]         r_erro;
  logic [1:0]         w_erro_nxt;
  logic               w_push;
  logic [ADDR_W-1:0]  w_seq;
  logic               w_conflict;
  logic               w_bad_tgt;
  logic [NIVEL_W-2:0] w_push_idx;
  logic [NIVEL_W-2:0] w_top_idx;

  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

  // Addresses stay below MEM_DEPTH, so wrapping only needs the last-line test.
  assign w_seq      = (r_linha == L_LAST) ? '0 : r_linha + 1'b1;
  assign w_conflict = (desvio & chamada) | (desvio & retorno) | (chamada & retorno);
  assign w_bad_tgt  = (desvio | chamada) & ({1'b0, alvo} >= L_DEPTH);
  assign w_push_idx = r_nivel[NIVEL_W-2:0];
  // Low bits of a full count wrap to zero, so subtracting one still gives the top slot.
  assign w_top_idx  = r_nivel[NIVEL_W-2:0] - 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_linha <= L_RESET;
      r_nivel <= '0;
      r_erro  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_linha <= w_linha_nxt;
      r_nivel <= w_nivel_nxt;
      r_erro  <= w_erro_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_seq;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_linha_nxt = r_linha;
    w_nivel_nxt = r_nivel;
    w_erro_nxt  = r_erro;
    w_push      = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_conflict || w_bad_tgt) begin
          w_state_nxt = S_HALT;
          w_erro_nxt  = E_CTRL;
        end else if (halt) begin
          w_state_nxt = S_HALT;
        end else if (stall) begin
          w_linha_nxt = r_linha;
        end else if (retorno) begin
          if (r_nivel == '0) begin
            w_state_nxt = S_HALT;
            w_erro_nxt  = E_UNF;
          end else begin
            w_linha_nxt = r_stack[w_top_idx];
            w_nivel_nxt = r_nivel - 1'b1;
          end
        end else if (chamada) begin
          if (r_nivel == L_FULL) begin
            w_state_nxt = S_HALT;
            w_erro_nxt  = E_OVF;
          end else begin
            w_push      = 1'b1;
            w_linha_nxt = alvo;
            w_nivel_nxt = r_nivel + 1'b1;
          end
        end else if (desvio) begin
          w_linha_nxt = alvo;
        end else begin
          w_linha_nxt = w_seq;
        end
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  always_comb begin
    valido = 1'b0;
    parado = 1'b0;
    case (r_state)
      S_RUN:   valido = 1'b1;
      S_HALT:  parado = 1'b1;
      default: begin
        valido = 1'b0;
        parado = 1'b0;
      end
    endcase
  end

  assign linha = r_linha;
  assign nivel = r_nivel;
  assign erro  = r_erro;

endmodule

// File: tb/tb_busca_pc.sv
// tb/tb_busca_pc.sv - self-checking bench for busca_pc
// Directed scenarios plus random control traffic against a queue-based model.
module tb_busca_pc;

  logic       clock;
  logic       reset;
  logic       stall;
  logic       halt;
  logic       desvio;
  logic       chamada;
  logic       retorno;
  logic [7:0] alvo;
  logic [7:0] linha;
  logic       valido;
  logic       parado;
  logic [1:0] erro;
  logic [2:0] nivel;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: 0 = boot, 1 = run, 2 = halt
  int m_state;
  int m_linha;
  int m_erro;
  int m_stk[$];

  busca_pc #(
    .ADDR_W(8),
    .MEM_DEPTH(16),
    .RESET_VEC(0),
    .STACK_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .halt(halt),
    .desvio(desvio),
    .chamada(chamada),
    .retorno(retorno),
    .alvo(alvo),
    .linha(linha),
    .valido(valido),
    .parado(parado),
    .erro(erro),
    .nivel(nivel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_linha = 0;
    m_erro  = 0;
    m_stk.delete();
  endtask

  task automatic model_step();
    int a;
    int n;
    a = int'(alvo);
    n = int'(desvio) + int'(chamada) + int'(retorno);
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (n > 1 || ((desvio || chamada) && a >= 16)) begin
        m_state = 2; m_erro = 3;
      end else if (halt) begin
        m_state = 2;
      end else if (stall) begin
        m_linha = m_linha;
      end else if (retorno) begin
        if (m_stk.size() == 0) begin
          m_state = 2; m_erro = 2;
        end else begin
          m_linha = m_stk.pop_back();
        end
      end else if (chamada) begin
        if (m_stk.size() == 4) begin
          m_state = 2; m_erro = 1;
        end else begin
          m_stk.push_back((m_linha + 1) % 16);
          m_linha = a;
        end
      end else if (desvio) begin
        m_linha = a;
      end else begin
        m_linha = (m_linha + 1) % 16;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".linha"},  int'(linha),  m_linha);
    chk({tag, ".valido"}, int'(valido), (m_state == 1) ? 1 : 0);
    chk({tag, ".parado"}, int'(parado), (m_state == 2) ? 1 : 0);
    chk({tag, ".erro"},   int'(erro),   m_erro);
    chk({tag, ".nivel"},  int'(nivel),  m_stk.size());
  endtask

  task automatic drv(input bit s, input bit h, input bit d, input bit c, input bit r, input int a);
    stall   = s;
    halt    = h;
    desvio  = d;
    chamada = c;
    retorno = r;
    alvo    = 8'(a);
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all(tag);
  endtask

  // Called just after a falling edge; reset is raised mid-cycle to exercise the async path.
  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst.linha",  int'(linha),  0);
    chk("rst.valido", int'(valido), 0);
    chk("rst.parado", int'(parado), 0);
    chk("rst.erro",   int'(erro),   0);
    chk("rst.nivel",  int'(nivel),  0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clock);

    // Idle run from reset: 0 twice, then sequential with wrap
    do_reset();
    step("boot");
    chk("boot.first", int'(linha), 0);
    chk("boot.valid", int'(valido), 1);
    repeat (17) step("idle");
    chk("idle.wrap", int'(linha), 1);

    // Branch then stalled branch
    do_reset();
    repeat (4) step("pre_br");
    chk("br.at3", int'(linha), 3);
    drv(0, 0, 1, 0, 0, 9);
    step("br");
    chk("br.tgt", int'(linha), 9);
    drv(0, 0, 0, 0, 0, 0);
    step("br_next");
    chk("br.next", int'(linha), 10);
    drv(1, 0, 1, 0, 0, 2);
    repeat (3) begin
      step("stall");
      chk("stall.hold", int'(linha), 10);
    end
    drv(0, 0, 0, 0, 0, 0);
    step("post_stall");
    chk("stall.resume", int'(linha), 11);

    // Call and return
    do_reset();
    repeat (5) step("pre_call");
    chk("call.at4", int'(linha), 4);
    drv(0, 0, 0, 1, 0, 12);
    step("call");
    chk("call.tgt", int'(linha), 12);
    chk("call.nivel", int'(nivel), 1);
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) step("in_call");
    chk("call.at14", int'(linha), 14);
    drv(0, 0, 0, 0, 1, 0);
    step("ret");
    chk("ret.addr", int'(linha), 5);
    chk("ret.nivel", int'(nivel), 0);

    // Stack overflow
    do_reset();
    step("boot_ovf");
    drv(0, 0, 0, 1, 0, 1);
    repeat (4) step("push");
    chk("ovf.full", int'(nivel), 4);
    step("ovf");
    chk("ovf.parado", int'(parado), 1);
    chk("ovf.erro", int'(erro), 1);
    chk("ovf.valido", int'(valido), 0);
    chk("ovf.linha", int'(linha), 1);

    // Underflow, conflict, target out of range
    do_reset();
    step("boot_unf");
    drv(0, 0, 0, 0, 1, 0);
    step("unf");
    chk("unf.erro", int'(erro), 2);
    chk("unf.parado", int'(parado), 1);
    do_reset();
    step("boot_cfl");
    drv(0, 0, 1, 1, 0, 3);
    step("cfl");
    chk("cfl.erro", int'(erro), 3);
    do_reset();
    step("boot_rng");
    drv(0, 0, 1, 0, 0, 20);
    step("rng");
    chk("rng.erro", int'(erro), 3);
    chk("rng.parado", int'(parado), 1);

    // Halt freezes the address; then asynchronous reset out of HALT
    do_reset();
    repeat (8) step("pre_halt");
    chk("halt.at7", int'(linha), 7);
    drv(0, 1, 0, 0, 0, 0);
    step("halt");
    chk("halt.parado", int'(parado), 1);
    repeat (10) begin
      drv(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 31));
      step("halted");
      chk("halt.frozen", int'(linha), 7);
    end
    do_reset();

    // Random control traffic
    repeat (25) begin
      int n;
      do_reset();
      n = $urandom_range(20, 80);
      repeat (n) begin
        int a;
        a = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
        drv($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, a);
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
